// File: rtl/ram8_march_bist.sv
// ram8_march_bist: March BIST initiator for an 8x16 RAM (w P / r P w ~P / r ~P w P / r P)
// with first-failure capture and a one-cycle done pulse.
module ram8_march_bist #(
   parameter int WIDTH = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH = 8,
   parameter logic [WIDTH-1:0] PATTERN = 16'h5555
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [WIDTH-1:0]  fail_data,
   output logic [WIDTH-1:0]  fail_exp,
   output logic [WIDTH-1:0]  mem_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_load,
   input  logic [WIDTH-1:0]  mem_out
);
   typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, FIN} state_t;
   state_t state, ns;
   logic [ADDR_W:0] k, nk;
   logic [WIDTH-1:0] exp_data;
   logic mismatch, last;
   always_comb begin
      exp_data = state == M2 ? ~PATTERN : PATTERN;
      mismatch = (state == M1 || state == M2 || state == M3) && mem_out != exp_data;
      last = k == (ADDR_W+1)'(DEPTH - 1);
      ns = state;
      nk = '0;
      if (state == IDLE)
         ns = start ? M0 : IDLE;
      else if (state == FIN)
         ns = IDLE;
      else if (mismatch)
         ns = FIN;
      else if (last)
         ns = state_t'(state + 3'd1);
      else
         nk = k + (ADDR_W+1)'(1);
   end
   // Outputs are registered from the next state, so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         mem_load <= 1'b0;
         mem_addr <= '0;
         mem_in <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         fail_exp <= '0;
      end else begin
         state <= ns;
         k <= nk;
         busy <= ns == M0 || ns == M1 || ns == M2 || ns == M3;
         done <= ns == FIN;
         mem_load <= ns == M0 || ns == M1 || ns == M2;
         mem_addr <= (ns == M0 || ns == M1) ? nk[ADDR_W-1:0] :
                     (ns == M2 || ns == M3) ? ADDR_W'(DEPTH - 1) - nk[ADDR_W-1:0] : '0;
         mem_in <= (ns == M0 || ns == M2) ? PATTERN : ns == M1 ? ~PATTERN : '0;
         if (state == IDLE && start) begin
            pass <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp <= '0;
         end
         if (mismatch) begin
            fail_addr <= mem_addr;
            fail_data <= mem_out;
            fail_exp <= exp_data;
         end
         if (ns == FIN)
            pass <= !mismatch;
      end
   end
endmodule

// File: tb/tb_ram8_march_bist.sv
// tb_ram8_march_bist: drives the BIST against a RAM with injectable stuck-at bits and
// checks every cycle against an algorithmic March model.
module tb_ram8_march_bist;
   localparam logic [15:0] P = 16'h5555;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic busy, done, pass, mem_load;
   logic [2:0] fail_addr, mem_addr;
   logic [15:0] fail_data, fail_exp, mem_in, mem_out;
   logic [15:0] ram [8];
   logic [15:0] and_m [8];
   logic [15:0] or_m [8];
   int pass_cnt = 0, total = 0;
   int exp_a [64];
   logic exp_l [64];
   logic [15:0] exp_in [64];
   int n_act;
   logic mp;
   logic [2:0] mfa;
   logic [15:0] mfd, mfe;
   int got_done_c;
   logic got_pass;
   logic [2:0] got_fa;
   logic [15:0] got_fd, got_fe;

   typedef struct {
      int fa;
      logic [15:0] am, om;
      logic pass;
      logic [2:0] faddr;
      logic [15:0] fdata, fexp;
      int done_c;
   } vec_t;
   vec_t tbl [3];

   ram8_march_bist dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp),
      .mem_in(mem_in), .mem_addr(mem_addr), .mem_load(mem_load), .mem_out(mem_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;
   assign mem_out = (ram[mem_addr] & and_m[mem_addr]) | or_m[mem_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic set_fault(input int a, input logic [15:0] am, input logic [15:0] om);
      for (int i = 0; i < 8; i++) begin
         and_m[i] = 16'hFFFF;
         or_m[i] = 16'h0000;
      end
      if (a >= 0) begin
         and_m[a] = am;
         or_m[a] = om;
      end
   endtask

   // Walks the March elements over a faulty array and records the expected port trace.
   task automatic model();
      logic [15:0] m [8];
      logic [15:0] rd, want;
      int a;
      bit stop;
      n_act = 0; mp = 1'b1; mfa = '0; mfd = '0; mfe = '0; stop = 0;
      for (int i = 0; i < 8; i++) m[i] = '0;
      for (int e = 0; e < 4 && !stop; e++)
         for (int i = 0; i < 8 && !stop; i++) begin
            a = e < 2 ? i : 7 - i;
            n_act++;
            exp_a[n_act] = a;
            exp_l[n_act] = e < 3;
            exp_in[n_act] = e == 1 ? ~P : P;
            rd = (m[a] & and_m[a]) | or_m[a];
            want = e == 2 ? ~P : P;
            if (e > 0 && rd != want) begin
               mp = 1'b0; mfa = 3'(a); mfd = rd; mfe = want; stop = 1;
            end
            if (e < 3) m[a] = exp_in[n_act];
         end
   endtask

   task automatic run_and_check(input string tag);
      model();
      got_done_c = -1; got_pass = 1'bx; got_fa = 'x; got_fd = 'x; got_fe = 'x;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c <= n_act + 3; c++) begin
         if (done && got_done_c < 0) begin
            got_done_c = c; got_pass = pass; got_fa = fail_addr; got_fd = fail_data; got_fe = fail_exp;
         end
         chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c <= n_act));
         chk($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == n_act + 1));
         chk($sformatf("%s c%0d load", tag, c), 32'(mem_load), 32'(c <= n_act && exp_l[c]));
         if (c <= n_act) begin
            chk($sformatf("%s c%0d addr", tag, c), 32'(mem_addr), 32'(exp_a[c]));
            if (exp_l[c]) chk($sformatf("%s c%0d din", tag, c), 32'(mem_in), 32'(exp_in[c]));
         end else begin
            chk($sformatf("%s c%0d idle_addr", tag, c), 32'(mem_addr), 0);
            chk($sformatf("%s c%0d idle_din", tag, c), 32'(mem_in), 0);
         end
         if (c == 1) begin
            chk($sformatf("%s clr_pass", tag), 32'(pass), 0);
            chk($sformatf("%s clr_faddr", tag), 32'(fail_addr), 0);
            chk($sformatf("%s clr_fdata", tag), 32'(fail_data), 0);
            chk($sformatf("%s clr_fexp", tag), 32'(fail_exp), 0);
         end
         if (c == n_act + 1) begin
            chk($sformatf("%s pass", tag), 32'(pass), 32'(mp));
            chk($sformatf("%s faddr", tag), 32'(fail_addr), 32'(mfa));
            chk($sformatf("%s fdata", tag), 32'(fail_data), 32'(mfd));
            chk($sformatf("%s fexp", tag), 32'(fail_exp), 32'(mfe));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int dcnt;
      tbl[0] = '{-1, 16'hFFFF, 16'h0000, 1'b1, 3'd0, 16'h0000, 16'h0000, 33};
      tbl[1] = '{5, 16'hFFFF, 16'h0001, 1'b0, 3'd5, 16'hAAAB, 16'hAAAA, 20};
      tbl[2] = '{2, 16'h7FFF, 16'h0000, 1'b0, 3'd2, 16'h2AAA, 16'hAAAA, 23};
      set_fault(-1, '0, '0);
      for (int i = 0; i < 8; i++) ram[i] = 16'(i);
      #12;
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst pass", 32'(pass), 0);
      chk("rst load", 32'(mem_load), 0);
      chk("rst addr", 32'(mem_addr), 0);
      chk("rst din", 32'(mem_in), 0);
      chk("rst fail", 32'({fail_addr, fail_data, fail_exp} != 0), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 3; t++) begin
         set_fault(tbl[t].fa, tbl[t].am, tbl[t].om);
         run_and_check($sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d done_cycle", t), 32'(got_done_c), 32'(tbl[t].done_c));
         chk($sformatf("tbl%0d pass", t), 32'(got_pass), 32'(tbl[t].pass));
         chk($sformatf("tbl%0d faddr", t), 32'(got_fa), 32'(tbl[t].faddr));
         chk($sformatf("tbl%0d fdata", t), 32'(got_fd), 32'(tbl[t].fdata));
         chk($sformatf("tbl%0d fexp", t), 32'(got_fe), 32'(tbl[t].fexp));
         if (t == 0)
            for (int i = 0; i < 8; i++) chk($sformatf("final ram%0d", i), 32'(ram[i]), 32'(P));
      end

      for (int r = 0; r < 8; r++) begin
         int a, b;
         a = $urandom_range(0, 7);
         b = $urandom_range(0, 15);
         if ($urandom_range(0, 2) == 0) set_fault(-1, '0, '0);
         else if ($urandom_range(0, 1) == 0) set_fault(a, ~(16'h1 << b), 16'h0);
         else set_fault(a, 16'hFFFF, 16'h1 << b);
         run_and_check($sformatf("rnd%0d", r));
      end

      // Abort during M1 at address 3, then confirm a clean rerun.
      set_fault(-1, '0, '0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 12; c++) @(negedge clk);
      chk("abort pre addr", 32'(mem_addr), 3);
      chk("abort pre load", 32'(mem_load), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort load", 32'(mem_load), 0);
      chk("abort busy", 32'(busy), 0);
      chk("abort pass", 32'(pass), 0);
      dcnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         dcnt += 32'(done);
      end
      chk("abort no done", 32'(dcnt), 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_and_check("after_abort");

      // start held high: second run only once IDLE sees it.
      @(negedge clk); start = 1'b1;
      dcnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         dcnt += 32'(done);
         if (c == 33) chk("hold done c33", 32'(done), 1);
         if (c == 34) begin
            chk("hold idle busy", 32'(busy), 0);
            chk("hold idle load", 32'(mem_load), 0);
            chk("hold idle addr", 32'(mem_addr), 0);
            chk("hold idle din", 32'(mem_in), 0);
            chk("hold idle pass", 32'(pass), 1);
         end
         if (c == 35) begin
            chk("hold restart busy", 32'(busy), 1);
            chk("hold restart pass", 32'(pass), 0);
         end
      end
      start = 1'b0;
      chk("hold done count", 32'(dcnt), 1);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/ram8_march_bist.md
Name: ram8_march_bist

Overview:
- Built-in self-test initiator for an 8-word x 16-bit RAM.
- Drives the RAM write side (data in, address, load) and checks the RAM's read data, so it sits on the opposite end of the RAM interface from the memory.
- Runs a fixed 4-element March sequence on one start pulse and reports pass/fail with first-failure capture.
- Sits between the RAM and the system test/debug logic; the system muxes it onto the RAM port only while busy=1.

Parameters:
- WIDTH, 16, data word width.
- ADDR_W, 3, address width.
- DEPTH, 8, number of words tested (2**ADDR_W).
- PATTERN, 16'h5555, background pattern P; its complement ~P is also used.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a test run; ignored unless idle.
- busy  output  1  high while the March sequence is running.
- done  output  1  one-cycle pulse when a run ends (pass or fail).
- pass  output  1  result of the last run; valid from the done pulse until the next start.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_data  output  WIDTH  data read at the first mismatch.
- fail_exp  output  WIDTH  expected data at the first mismatch.
- mem_in  output  WIDTH  write data to the RAM.
- mem_addr  output  ADDR_W  RAM address.
- mem_load  output  1  RAM write enable; the RAM writes on the rising clk edge.
- mem_out  input  WIDTH  RAM read data; combinational from mem_addr, so it reflects the old contents during a write cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, pass, mem_load = 0; mem_addr, mem_in, fail_addr, fail_data, fail_exp = 0.
- Reset mid-run aborts immediately: mem_load drops without waiting for a clock; no done pulse; pass=0.
- All outputs are registered.
- States: IDLE, M0, M1, M2, M3, FIN.
- Cycle index k runs 0..DEPTH-1 within each element; there is one address per cycle.
- M0 (ascending, write P): mem_addr=k, mem_in=P, mem_load=1.
- M1 (ascending, read P / write ~P): mem_addr=k, mem_in=~P, mem_load=1. mem_out is compared against P at the same edge that performs the write.
- M2 (descending, read ~P / write P): mem_addr=DEPTH-1-k, mem_in=P, mem_load=1. Compare against ~P.
- M3 (descending, read P): mem_addr=DEPTH-1-k, mem_load=0. Compare against P.
- Transitions:
  - IDLE -> M0 on start=1 at edge N; busy=1 and the first M0 cycle is cycle N+1.
  - Each element advances to the next after its k=DEPTH-1 cycle: M0 -> M1 -> M2 -> M3 -> FIN.
  - FIN lasts one cycle with done=1, busy=0, mem_load=0, then returns to IDLE.
- Latency: a fault-free run uses 4*DEPTH=32 active cycles, with done in cycle N+33.
- Mismatch handling:
  - On the first mismatch, latch fail_addr, fail_data (mem_out) and fail_exp.
  - The write already presented in that cycle completes.
  - Next cycle is FIN with pass=0; remaining elements are skipped.
- No mismatch: pass=1 in FIN.
- fail_* registers are cleared to 0 on each accepted start and hold their value until the next start.
- start while busy or in FIN is ignored: no restart, no effect on counters.
- start in the same cycle FIN returns to IDLE is not accepted; start must be seen in IDLE.
- In IDLE: mem_load=0, mem_addr=0, mem_in=0. The port is safe to mux back to the host.
- k counter is ADDR_W+1 bits wide to detect end-of-element without wrapping ambiguity; addresses never wrap mid-element.

Test Plan:
- Fault-free 8x16 RAM model, start pulse at edge N:
  - busy rises at N+1.
  - Addresses 0..7, 0..7, 7..0, 7..0.
  - mem_load high for 24 cycles.
  - done at N+33 with pass=1.
  - Final RAM contents all 16'h5555.
- Word 5 bit 0 stuck-at-1:
  - M2 reads addr 5 at N+19 and sees 16'hAAAB.
  - Required: fail_addr=5, fail_data=16'hAAAB, fail_exp=16'hAAAA, done at N+20, pass=0.
  - No further mem_load after N+19.
- Word 2 bit 15 stuck-at-0:
  - Fails in M2 at addr 2, since it wrote ~P=16'hAAAA and reads 16'h2AAA.
  - Required: fail_addr=2, fail_exp=16'hAAAA, fail_data=16'h2AAA, pass=0.
- rst_n pulsed low during M1 (address 3):
  - mem_load and busy go 0 asynchronously; no done pulse.
  - A new start after release produces a full passing run.
- start held high for 40 cycles:
  - Exactly one run is performed; done occurs once.
  - A second run begins only after start is seen in IDLE; verify pass/fail_* are cleared on that second start.
